// File: rtl/circ_smpl_queue.sv
`timescale 1ns / 1ps
// Circular stereo sample queue. Every DEPTH-sample window is streamed oldest to newest
// to a downstream FIR, through a registered synchronous read port.
module circ_smpl_queue #(
  parameter int unsigned DEPTH = 1021
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wrt_smpl,
  input  logic signed [15:0] lft_smpl,
  input  logic signed [15:0] rht_smpl,
  output logic               sequencing,
  output logic signed [15:0] lft_out,
  output logic signed [15:0] rht_out,
  output logic               overrun
);

  localparam logic [9:0] DepthW  = 10'(DEPTH);
  localparam logic [9:0] LastIdx = 10'(DEPTH - 1);

  typedef enum logic {StIdle, StRun} state_e;

  logic [31:0]        mem [DEPTH];
  logic [31:0]        rd_data;
  state_e             state_q, state_d;
  logic [9:0]         wptr_q, wptr_d;
  logic [9:0]         rptr_q, rptr_d;
  logic [9:0]         cnt_q, cnt_d;
  logic [9:0]         k_q, k_d;
  logic               pend_q, pend_d;
  logic               overrun_q, overrun_d;
  logic signed [15:0] lft_out_q, lft_out_d;
  logic signed [15:0] rht_out_q, rht_out_d;

  // Sample storage: never reset, writes accepted in any state. The output register is
  // loaded on the same edge, so a same-address access returns the old contents.
  always_ff @(posedge clk) begin
    if (wrt_smpl) begin
      mem[wptr_q] <= {lft_smpl, rht_smpl};
    end
  end

  // Next-state: pointers, fill count, run sequencing, pending-run and overrun tracking.
  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    pend_d    = pend_q;
    lft_out_d = lft_out_q;
    rht_out_d = rht_out_q;
    rd_data   = mem[rptr_q];

    // pend_q can only be set in RUN or in the single gap cycle after it, so a write seen
    // with pend_q high is always a second write folded into one follow-up run.
    overrun_d = overrun_q | (wrt_smpl & pend_q);

    if (wrt_smpl) begin
      wptr_d = (wptr_q == LastIdx) ? 10'd0 : wptr_q + 10'd1;
      if (cnt_q != DepthW) begin
        cnt_d = cnt_q + 10'd1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if ((wrt_smpl && (cnt_d == DepthW)) || pend_q) begin
          state_d = StRun;
          rptr_d  = wptr_d;  // oldest sample once this cycle's write has landed
          k_d     = 10'd0;
          pend_d  = 1'b0;
        end
      end
      StRun: begin
        lft_out_d = rd_data[31:16];
        rht_out_d = rd_data[15:0];
        if (wrt_smpl) begin
          pend_d = 1'b1;
        end
        if (k_q == DepthW) begin
          state_d = StIdle;
          k_d     = 10'd0;
        end else begin
          k_d    = k_q + 10'd1;
          rptr_d = (rptr_q == LastIdx) ? 10'd0 : rptr_q + 10'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      wptr_q    <= 10'd0;
      rptr_q    <= 10'd0;
      cnt_q     <= 10'd0;
      k_q       <= 10'd0;
      pend_q    <= 1'b0;
      overrun_q <= 1'b0;
      lft_out_q <= 16'sd0;
      rht_out_q <= 16'sd0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      pend_q    <= pend_d;
      overrun_q <= overrun_d;
      lft_out_q <= lft_out_d;
      rht_out_q <= rht_out_d;
    end
  end

  assign sequencing = (state_q == StRun);
  assign lft_out    = lft_out_q;
  assign rht_out    = rht_out_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_circ_smpl_queue.sv
`timescale 1ns / 1ps
// Directed bench for circ_smpl_queue: expected windows come from a history of written samples.
module tb_circ_smpl_queue;

  localparam int unsigned DEPTH = 1021;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               wrt_smpl;
  logic signed [15:0] lft_smpl;
  logic signed [15:0] rht_smpl;
  logic               sequencing;
  logic signed [15:0] lft_out;
  logic signed [15:0] rht_out;
  logic               overrun;

  int                 n_vec  = 0;
  int                 n_err  = 0;
  logic signed [15:0] hist [4096];
  int                 n_hist = 0;

  always #5 clk = ~clk;

  circ_smpl_queue #(.DEPTH(DEPTH)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wrt_smpl   (wrt_smpl),
    .lft_smpl   (lft_smpl),
    .rht_smpl   (rht_smpl),
    .sequencing (sequencing),
    .lft_out    (lft_out),
    .rht_out    (rht_out),
    .overrun    (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Present a write for the current cycle and record it in the history.
  task automatic drive_wr(input logic signed [15:0] v);
    wrt_smpl = 1'b1;
    lft_smpl = v;
    rht_smpl = -v;
    hist[n_hist] = v;
    n_hist++;
  endtask

  task automatic wr(input logic signed [15:0] v);
    drive_wr(v);
    @(posedge clk); #1;
    wrt_smpl = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      chk("idle_seq", 32'(sequencing), 32'd0);
    end
  endtask

  // Called at run cycle 0. Optional writes at run cycles wa/wb, optional reset at run cycle ab.
  task automatic check_run(input int wa, input logic signed [15:0] va,
                           input int wb, input logic signed [15:0] vb, input int ab);
    int                 base;
    logic signed [15:0] el;
    logic signed [15:0] er;
    base = n_hist - int'(DEPTH);
    for (int k = 0; k <= int'(DEPTH); k++) begin
      chk("run_seq", 32'(sequencing), 32'd1);
      if (k > 0) begin
        el = hist[base + k - 1];
        er = -el;
        chk("run_lft", 32'(lft_out), 32'(el));
        chk("run_rht", 32'(rht_out), 32'(er));
      end
      if (k == wa) drive_wr(va);
      if (k == wb) drive_wr(vb);
      if (k == ab) rst_n = 1'b0;
      @(posedge clk); #1;
      wrt_smpl = 1'b0;
      if (k == ab) begin
        rst_n = 1'b1;
        chk("rst_seq", 32'(sequencing), 32'd0);
        chk("rst_lft", 32'(lft_out), 32'd0);
        chk("rst_rht", 32'(rht_out), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        return;
      end
    end
    chk("gap_seq", 32'(sequencing), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    wrt_smpl = 1'b0;
    lft_smpl = 16'sd0;
    rht_smpl = 16'sd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset_seq", 32'(sequencing), 32'd0);
    chk("reset_lft", 32'(lft_out), 32'd0);
    chk("reset_rht", 32'(rht_out), 32'd0);
    chk("reset_ovr", 32'(overrun), 32'd0);

    // One short of a full window: no run, outputs stay 0.
    for (int i = 0; i < 1020; i++) begin
      wr(16'(i));
      chk("fill_seq", 32'(sequencing), 32'd0);
    end
    chk("fill_lft", 32'(lft_out), 32'd0);
    chk("fill_rht", 32'(rht_out), 32'd0);

    // Completing write: window 0..1020.
    wr(16'sd1020);
    check_run(-1, 16'sd0, -1, 16'sd0, -1);

    // Wrap write: window 1..1021, plus a write at run cycle 500 for a second run.
    idle(2);
    wr(16'sd1021);
    check_run(500, 16'sd2000, -1, 16'sd0, -1);
    @(posedge clk); #1;
    check_run(-1, 16'sd0, -1, 16'sd0, -1);
    chk("single_ovr", 32'(overrun), 32'd0);
    idle(4);

    // Two writes in one run (first one on the slot being read): one merged follow-up, overrun.
    wr(16'sd3000);
    check_run(0, 16'sd3001, 700, 16'sd3002, -1);
    chk("double_ovr", 32'(overrun), 32'd1);
    @(posedge clk); #1;
    check_run(-1, 16'sd0, -1, 16'sd0, -1);
    idle(5);
    chk("merged_ovr", 32'(overrun), 32'd1);
    wr(16'sd3003);
    check_run(-1, 16'sd0, -1, 16'sd0, -1);
    chk("sticky_ovr", 32'(overrun), 32'd1);

    // Reset mid-run, then refill from empty.
    idle(2);
    wr(16'sd4000);
    check_run(-1, 16'sd0, -1, 16'sd0, 300);
    for (int i = 0; i < 1020; i++) begin
      wr(16'(5000 + i));
      chk("refill_seq", 32'(sequencing), 32'd0);
    end
    wr(16'sd6020);
    check_run(-1, 16'sd0, -1, 16'sd0, -1);
    chk("refill_ovr", 32'(overrun), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/circ_smpl_queue.md
CIRC_SMPL_QUEUE -- requirements
Module: circ_smpl_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 1021, meaning number of stereo samples per filter window (one per FIR tap).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous and active-low.
REQ-004 SHALL have port wrt_smpl  input  1  one-cycle strobe; new stereo sample present on lft_smpl/rht_smpl.
REQ-005 SHALL have port lft_smpl  input  16  signed left sample.
REQ-006 SHALL have port rht_smpl  input  16  signed right sample.
REQ-007 SHALL have port sequencing  output  1  high while a window is streamed to the downstream FIR.
REQ-008 SHALL have port lft_out  output  16  signed left window sample, registered.
REQ-009 SHALL have port rht_out  output  16  signed right window sample, registered.
REQ-010 SHALL have port overrun  output  1  sticky error flag: a write was lost from the run schedule.

Function
REQ-011 SHALL store samples in a DEPTH-entry, 32-bit-wide (L,R) circular memory with 10-bit write pointer wptr; no storage is added for the memory-read register.
REQ-012 SHALL write {lft_smpl,rht_smpl} to mem[wptr] on every cycle wrt_smpl=1, in any state, and advance wptr; wptr wraps DEPTH-1 -> 0 (not a power-of-two wrap).
REQ-013 SHALL keep 10-bit fill count cnt, incremented per write, saturating at DEPTH.
REQ-014 SHALL implement FSM states IDLE and RUN.
REQ-015 IDLE -> RUN SHALL occur on the cycle after a write that leaves cnt==DEPTH, or after the mandatory gap cycle when pend=1; otherwise remain IDLE.
REQ-016 On RUN entry SHALL latch rptr = wptr (oldest sample) and clear index k to 0.
REQ-017 In RUN SHALL hold sequencing=1 for exactly DEPTH+1 consecutive cycles (k = 0..DEPTH).
REQ-018 SHALL issue memory read address for window element k during run cycle k (element 0 = oldest, element DEPTH-1 = newest), rptr wrapping as wptr.
REQ-019 lft_out/rht_out SHALL present window element k-1 on run cycle k for k = 1..DEPTH; run cycle 0 data is don't-care (consumer uses it to clear its accumulator).
REQ-020 Memory SHALL be read-first: simultaneous read and write of the same address returns the old contents.
REQ-021 After k==DEPTH SHALL return to IDLE with sequencing=0 for at least one cycle before any next run.
REQ-022 A write during RUN SHALL set pend=1; pend is consumed (cleared) on the next RUN entry.
REQ-023 A write during RUN while pend=1 already, or a write while in the gap cycle with pend=1, SHALL set overrun=1; writes are never dropped from memory, only runs are merged.
REQ-024 overrun SHALL remain 1 until reset.
REQ-025 No arithmetic on sample data; values pass bit-exact.

Reset
REQ-026 When rst_n=0 at a clock edge: wptr=0, rptr=0, cnt=0, k=0, pend=0, state=IDLE, sequencing=0, lft_out=0, rht_out=0, overrun=0, effective on the following cycle, including mid-run.
REQ-027 Memory contents SHALL NOT be cleared by reset; cnt gating guarantees stale data is never streamed.

Verification
REQ-028 Reset; write 1020 samples L=i, R=-i (i=0..1019) -> sequencing never asserts; outputs stay 0.
REQ-029 Write sample i=1020 -> sequencing high 1022 cycles starting cycle after the write; run cycle k outputs L=k-1, R=-(k-1) for k=1..1021; then low >= 1 cycle.
REQ-030 Write L=1021 after first run -> window L=1..1021 (oldest slot 0 overwritten, pointer wrap correct).
REQ-031 One write (L=2000) at run cycle 500 -> current run unaffected; one low cycle; second run starts with oldest L=2..., newest L=2000; overrun=0.
REQ-032 Two writes in one run -> both stored, only one follow-up run, overrun=1 and stays 1 through later runs.
REQ-033 rst_n=0 at run cycle 300 -> sequencing=0, outputs 0 next cycle; 1020 further writes give no run, 1021st write starts one.
